// File: rtl/seq_divider_pkg.sv
// Shared ALU divider definitions: FSM state encoding, default datapath width and
// the quotient pattern reported on divide-by-zero.
package seq_divider_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // Sliced down to the configured width by the divider (WIDTH <= 64).
    localparam logic [63:0] DIV_ZERO_Q = {64{1'b1}};

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for the sequential divider.
// signed_op exists only when SEQ_DIVIDER_SIGNED_EN is defined.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic             signed_op;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             busy;

    modport master (
`ifdef SEQ_DIVIDER_SIGNED_EN
        output signed_op,
`endif
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
    );

    modport slave (
`ifdef SEQ_DIVIDER_SIGNED_EN
        input  signed_op,
`endif
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, busy
    );

endinterface

// File: rtl/div_sub_stage.sv
// One restoring-division trial subtraction: partial - divisor formed as
// partial + ~divisor + 1, with the carry out acting as the no-borrow flag.
module div_sub_stage #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   partial,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] difference,
    output logic             no_borrow
);
    logic [WIDTH+1:0] sum;
    logic             diff_msb_unused;

    // When no borrow occurs the difference is below the divisor, so its top bit is always zero.
    assign sum = {1'b0, partial} + {1'b0, ~{1'b0, divisor}} + (WIDTH+2)'(1);
    assign {no_borrow, diff_msb_unused, difference} = sum;

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring DIV/REM unit: one quotient bit per cycle, valid/ready on both sides.
// Define SEQ_DIVIDER_SIGNED_EN to add bus.signed_op and two's-complement division.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input logic          clk,
    input logic          rst_n,
    seq_divider_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] dvd_q;      // dividend bits shift out of the top, quotient bits shift in below
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH-1:0] rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             q_neg_q, r_neg_q;
    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic             dbz_q;

    logic             accept, divisor_zero, last_iter, no_borrow;
    logic             q_neg_in, r_neg_in;
    logic [WIDTH-1:0] dvd_mag, dsr_mag;
    logic [WIDTH:0]   partial;
    logic [WIDTH-1:0] diff, rem_next, quo_next, q_final, r_final;

    assign accept       = bus.in_valid && (state_q == DIV_IDLE);
    assign divisor_zero = (bus.divisor == '0);
    assign last_iter    = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic dvd_neg, dsr_neg;

    // The most-negative value negates to itself, which is its correct magnitude read unsigned.
    assign dvd_neg  = bus.signed_op && bus.dividend[WIDTH-1];
    assign dsr_neg  = bus.signed_op && bus.divisor[WIDTH-1];
    assign dvd_mag  = dvd_neg ? -bus.dividend : bus.dividend;
    assign dsr_mag  = dsr_neg ? -bus.divisor : bus.divisor;
    assign q_neg_in = dvd_neg ^ dsr_neg;
    assign r_neg_in = dvd_neg;
`else
    assign dvd_mag  = bus.dividend;
    assign dsr_mag  = bus.divisor;
    assign q_neg_in = 1'b0;
    assign r_neg_in = 1'b0;
`endif

    // Partial remainder kept WIDTH+1 wide so a remainder with its MSB set is not truncated.
    assign partial = {rem_q, dvd_q[WIDTH-1]};

    div_sub_stage #(.WIDTH(WIDTH)) u_sub (
        .partial   (partial),
        .divisor   (dsr_q),
        .difference(diff),
        .no_borrow (no_borrow)
    );

    assign rem_next = no_borrow ? diff : partial[WIDTH-1:0];
    assign quo_next = {dvd_q[WIDTH-2:0], no_borrow};
    assign q_final  = q_neg_q ? -quo_next : quo_next;
    assign r_final  = r_neg_q ? -rem_next : rem_next;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            DIV_IDLE: if (accept)        state_d = divisor_zero ? DIV_DONE : DIV_CALC;
            DIV_CALC: if (last_iter)     state_d = DIV_DONE;
            DIV_DONE: if (bus.out_ready) state_d = DIV_IDLE;
            default:                     state_d = DIV_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state_q)
            DIV_IDLE: bus.in_ready  = 1'b1;
            DIV_CALC: bus.busy      = 1'b1;
            DIV_DONE: bus.out_valid = 1'b1;
            default:  bus.in_ready  = 1'b0;
        endcase
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

    // NOTE: the whole datapath is reset, not just control, so an aborted operation leaves all-zero outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q       <= '0;
            dsr_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else if (accept) begin
            dvd_q   <= dvd_mag;
            dsr_q   <= dsr_mag;
            rem_q   <= '0;
            cnt_q   <= '0;
            q_neg_q <= q_neg_in;
            r_neg_q <= r_neg_in;
            if (divisor_zero) begin
                quotient_q  <= DIV_ZERO_Q[WIDTH-1:0];
                remainder_q <= bus.dividend;
                dbz_q       <= 1'b1;
            end
        end else if (state_q == DIV_CALC) begin
            dvd_q <= quo_next;
            rem_q <= rem_next;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_iter) begin
                quotient_q  <= q_final;
                remainder_q <= r_final;
                dbz_q       <= 1'b0;
            end
        end
    end

endmodule
